// File: rtl/controle_cronometro_pkg.sv
// Shared definitions for the stopwatch front-panel control: FSM states and BCD word sizes.
package controle_cronometro_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 4 * DIGIT_W;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    VOLTA    = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_cronometro_debounce_botao.sv
// Push-button conditioning: 2-flop synchronizer, consecutive-sample debounce and press pulse.
module debounce_botao #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic evento
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic             nivel;
  logic [CNT_W-1:0] cnt;
  logic             difere;

  assign difere = (sync2 != nivel);

  // The press pulse fires on the same edge that commits the debounced 1->0 change.
  assign evento = difere && (cnt == LAST) && nivel;

  // Synchronizer and debounce counter; any sample matching the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      nivel <= 1'b1;
      cnt   <= {CNT_W{1'b0}};
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (!difere) begin
        cnt <= {CNT_W{1'b0}};
      end else if (cnt == LAST) begin
        nivel <= sync2;
        cnt   <= {CNT_W{1'b0}};
      end else begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch control: debounced buttons drive a run/pause/lap/clear FSM, a lap latch and the display mux.
module controle_cronometro
  import controle_cronometro_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 2
) (
  input  logic              clk_100hz,
  input  logic              reset,
  input  logic              key_start_n,
  input  logic              key_volta_n,
  input  logic [TIME_W-1:0] tempo_bcd,
  output logic              enable,
  output logic              zera_n,
  output logic              congela,
  output logic [TIME_W-1:0] volta_bcd,
  output logic [TIME_W-1:0] disp_bcd
);

  logic ev_start;
  logic ev_volta_raw;
  logic ev_volta;

  estado_t           estado;
  estado_t           prox_estado;
  logic              prox_zera_n;
  logic [TIME_W-1:0] prox_volta_bcd;

  debounce_botao #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_deb_start (
    .clk    (clk_100hz),
    .reset  (reset),
    .key_n  (key_start_n),
    .evento (ev_start)
  );

  debounce_botao #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_deb_volta (
    .clk    (clk_100hz),
    .reset  (reset),
    .key_n  (key_volta_n),
    .evento (ev_volta_raw)
  );

  // START has priority when both presses mature on the same edge.
  assign ev_volta = ev_volta_raw && !ev_start;

  // Next state, clear pulse and lap latch value.
  always_comb begin
    prox_estado    = estado;
    prox_zera_n    = 1'b1;
    prox_volta_bcd = volta_bcd;
    case (estado)
      PARADO: begin
        if (ev_start) begin
          prox_estado = CONTANDO;
        end else if (ev_volta) begin
          prox_zera_n    = 1'b0;
          prox_volta_bcd = {TIME_W{1'b0}};
        end else begin
          prox_estado = PARADO;
        end
      end
      CONTANDO: begin
        if (ev_start) begin
          prox_estado = PAUSADO;
        end else if (ev_volta) begin
          prox_estado    = VOLTA;
          prox_volta_bcd = tempo_bcd;
        end else begin
          prox_estado = CONTANDO;
        end
      end
      VOLTA: begin
        if (ev_start) begin
          prox_estado = PAUSADO;
        end else if (ev_volta) begin
          prox_estado = CONTANDO;
        end else begin
          prox_estado = VOLTA;
        end
      end
      PAUSADO: begin
        if (ev_start) begin
          prox_estado = CONTANDO;
        end else if (ev_volta) begin
          prox_estado    = PARADO;
          prox_zera_n    = 1'b0;
          prox_volta_bcd = {TIME_W{1'b0}};
        end else begin
          prox_estado = PAUSADO;
        end
      end
      default: begin
        prox_estado    = PARADO;
        prox_volta_bcd = {TIME_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; enable/freeze are decoded from the next state.
  always_ff @(posedge clk_100hz) begin
    if (!reset) begin
      estado    <= PARADO;
      enable    <= 1'b0;
      zera_n    <= 1'b1;
      congela   <= 1'b0;
      volta_bcd <= {TIME_W{1'b0}};
    end else begin
      estado    <= prox_estado;
      enable    <= (prox_estado == CONTANDO) || (prox_estado == VOLTA);
      zera_n    <= prox_zera_n;
      congela   <= (prox_estado == VOLTA);
      volta_bcd <= prox_volta_bcd;
    end
  end

  assign disp_bcd = congela ? volta_bcd : tempo_bcd;

endmodule
